// File: rtl/uart_pkg.sv
// Shared types and default baud constants for the buffered UART receiver.
package uart_pkg;

   localparam int unsigned DEFAULT_HALF_INTERVAL = 433;
   localparam int unsigned DEFAULT_INTERVAL      = 868;
   localparam int unsigned BYTE_W                = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO; fullness and emptiness come from the registered count.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BYTE_W,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_push;
   logic                  do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // A push while full is dropped even if a pop happens in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: pin synchroniser, baud-counter deserialiser and a byte FIFO
// drained by the core with a valid/ready handshake.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned HALF_INTERVAL   = DEFAULT_HALF_INTERVAL,
   parameter int unsigned INTERVAL        = DEFAULT_INTERVAL,
   parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_error,
   output logic       overrun
);

   localparam int unsigned CNT_W = $clog2(INTERVAL);
   // Counter is cleared on the IDLE exit, so it reads HALF_INTERVAL-1 at t0+HALF_INTERVAL.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_INTERVAL - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(INTERVAL - 1);

   logic [1:0]       sync;
   logic             rx_s;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   assign rx_s      = sync[1];
   assign push      = (state == STOP) && (cnt == BIT_LAST) && rx_s;
   assign pop       = out_valid && out_ready;
   assign out_valid = !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], uart_rx};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               cnt <= cnt + 1'b1;
               if (cnt == HALF_LAST) begin
                  if (!rx_s) begin
                     cnt     <= '0;
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               cnt <= cnt + 1'b1;
               if (cnt == BIT_LAST) begin
                  shift   <= {rx_s, shift[7:1]};
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               cnt <= cnt + 1'b1;
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     overrun <= full;
                     state   <= IDLE;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= BREAK;
                  end
               end
            end
            BREAK: begin
               // A held-low line must return high before a new frame is accepted.
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   byte_fifo #(
      .DATA_WIDTH (BYTE_W),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shift),
      .full      (full),
      .pop       (pop),
      .pop_data  (out_data),
      .empty     (empty)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered with a shortened baud interval; a negedge
// monitor collects delivered bytes and error pulses for comparison.
module tb_uart_rx_buffered;
   import uart_pkg::*;

   localparam int unsigned HALF    = 7;
   localparam int unsigned INTV    = 16;
   localparam int unsigned AW      = 4;
   // Stop sample to start drive: sync (2) + IDLE exit (1) + HALF-1 + 9 bit intervals.
   localparam int unsigned STOP_AT = HALF + 9 * INTV + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_rx;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_error;
   logic       overrun;

   int n_checks = 0;
   int n_errors = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int chk_idx  = 0;
   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];

   uart_rx_buffered #(
      .HALF_INTERVAL   (HALF),
      .INTERVAL        (INTV),
      .FIFO_ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_rx     (uart_rx),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .frame_error (frame_error),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) rx_q.push_back(out_data);
         if (frame_error) fe_cnt++;
         if (overrun) ov_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives start, 8 data bits LSB first and the stop bit, each INTV cycles; idles high after a good stop.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         tick(INTV);
      end
      if (stop) uart_rx = 1'b1;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      tick(n);
      out_ready = 1'b0;
   endtask

   task automatic check_rx(input string tag);
      int n;
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = chk_idx; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      end
      chk_idx = exp_q.size();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fe0;
      int ov0;
      logic [7:0] b;

      reset     = 1'b1;
      uart_rx   = 1'b1;
      out_ready = 1'b0;
      tick(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_fe", 32'(frame_error), 32'd0);
      check("rst_ov", 32'(overrun), 32'd0);
      reset = 1'b0;
      tick(5);

      // Single byte with exact out_valid timing, then a one-cycle pop.
      fe0 = fe_cnt;
      fork
         send_frame(8'h55, 1'b1);
         begin
            @(posedge clk);
            repeat (STOP_AT) @(posedge clk);
            @(negedge clk);
            check("single_valid_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("single_valid_rise", 32'(out_valid), 32'd1);
            check("single_data", 32'(out_data), 32'h55);
         end
      join
      tick(5);
      check("single_fe", 32'(fe_cnt - fe0), 32'd0);
      drain(1);
      @(negedge clk);
      check("single_pop_valid", 32'(out_valid), 32'd0);
      exp_q.push_back(8'h55);
      check_rx("single");
      tick(3);

      // Low pulse shorter than half a bit is rejected.
      fe0 = fe_cnt;
      uart_rx = 1'b0;
      tick(4);
      uart_rx = 1'b1;
      tick(30);
      check("glitch_valid", 32'(out_valid), 32'd0);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
      check("glitch_state", 32'(dut.state), 32'(IDLE));
      send_frame(8'hA3, 1'b1);
      tick(5);
      drain(3);
      exp_q.push_back(8'hA3);
      check_rx("glitch");

      // Bad stop bit followed by a long break.
      fe0 = fe_cnt;
      send_frame(8'h0F, 1'b0);
      tick(2000);
      check("frame_fe_once", 32'(fe_cnt - fe0), 32'd1);
      check("frame_no_push", 32'(out_valid), 32'd0);
      uart_rx = 1'b1;
      tick(10);
      send_frame(8'h7E, 1'b1);
      tick(5);
      drain(3);
      exp_q.push_back(8'h7E);
      check_rx("frame");

      // Seventeen bytes into a sixteen-deep FIFO.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1);
      end
      tick(5);
      check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
      check("ovr_fe", 32'(fe_cnt - fe0), 32'd0);
      check("ovr_full_valid", 32'(out_valid), 32'd1);
      check("ovr_head", 32'(out_data), 32'h00);
      drain(20);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
      end
      check_rx("ovr");
      check("ovr_empty", 32'(out_valid), 32'd0);

      // Reset during data bit 4 with three bytes queued.
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      tick(5);
      check("mid_queued", 32'(out_valid), 32'd1);
      fork
         send_frame(8'h44, 1'b1);
         begin
            @(posedge clk);
            repeat (4 * INTV + 24) @(posedge clk);
            #3;
            reset = 1'b1;
            #1;
            check("mid_rst_valid", 32'(out_valid), 32'd0);
            check("mid_rst_data", 32'(out_data), 32'd0);
            check("mid_rst_fe", 32'(frame_error), 32'd0);
            check("mid_rst_ov", 32'(overrun), 32'd0);
         end
      join
      tick(1);
      reset = 1'b0;
      tick(10);
      check("mid_empty", 32'(out_valid), 32'd0);
      check("mid_state", 32'(dut.state), 32'(IDLE));
      send_frame(8'hC9, 1'b1);
      tick(5);
      check("mid_c9", 32'(out_data), 32'hC9);
      drain(3);
      exp_q.push_back(8'hC9);
      check_rx("mid");

      // Back-to-back random stream with the consumer always ready.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 1'b1);
      end
      tick(40);
      out_ready = 1'b0;
      check_rx("stream");
      check("stream_ov", 32'(ov_cnt - ov0), 32'd0);
      check("stream_fe", 32'(fe_cnt - fe0), 32'd0);
      check("stream_empty", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
